// File: rtl/reg_read_stage_pkg.sv
// Shared types and constants for the register-read stage: word/address
// widths, the architectural PC register number and the operand-source
// selection used by each operand mux.
package reg_read_stage_pkg;

   localparam int WORD       = 32;
   localparam int ADDR_WIDTH = 4;
   localparam int PC_REG     = 15;

   typedef logic [WORD-1:0]       word_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;

   // Where a resolved operand comes from, in priority order.
   typedef enum logic [1:0] {
      SEL_ZERO = 2'd0,
      SEL_PC   = 2'd1,
      SEL_BYP  = 2'd2,
      SEL_RAM  = 2'd3
   } opsel_e;

   // Priority decision for one operand. r15 always reads the PC, so a
   // writeback to r15 is never bypassed.
   function automatic opsel_e f_op_sel(input logic  valid,
                                       input addr_t addr,
                                       input logic  byp_en,
                                       input addr_t byp_addr);
      if (!valid)                          return SEL_ZERO;
      if (addr == addr_t'(PC_REG))         return SEL_PC;
      if (byp_en && (byp_addr == addr))    return SEL_BYP;
      return SEL_RAM;
   endfunction

endpackage

// File: rtl/reg_read_stage_if.sv
// Bundle of decode, register-RAM, writeback, stall/flush and execute
// signals around the register-read stage. The stage uses the slave view;
// the surrounding pipeline (or a testbench) uses the master view.
interface reg_read_stage_if import reg_read_stage_pkg::*; #(
   parameter int CTRL_W = 32
) ();

   logic              dec_valid_i;
   addr_t             dec_addr_1_i;
   addr_t             dec_addr_2_i;
   addr_t             dec_addr_3_i;
   logic [CTRL_W-1:0] dec_ctrl_i;
   word_t             dec_pc_i;

   logic              stall_i;
   logic              flush_i;

   addr_t             ram_addr_1_o;
   addr_t             ram_addr_2_o;
   addr_t             ram_addr_3_o;
   word_t             ram_data_1_i;
   word_t             ram_data_2_i;
   word_t             ram_data_3_i;

   logic              wb_en_i;
   addr_t             wb_addr_i;
   word_t             wb_data_i;

   logic              ex_valid_o;
   word_t             ex_op_1_o;
   word_t             ex_op_2_o;
   word_t             ex_op_3_o;
   addr_t             ex_src_1_o;
   addr_t             ex_src_2_o;
   addr_t             ex_src_3_o;
   logic [CTRL_W-1:0] ex_ctrl_o;

   modport slave (
      input  dec_valid_i, dec_addr_1_i, dec_addr_2_i, dec_addr_3_i,
      input  dec_ctrl_i, dec_pc_i, stall_i, flush_i,
      output ram_addr_1_o, ram_addr_2_o, ram_addr_3_o,
      input  ram_data_1_i, ram_data_2_i, ram_data_3_i,
      input  wb_en_i, wb_addr_i, wb_data_i,
      output ex_valid_o, ex_op_1_o, ex_op_2_o, ex_op_3_o,
      output ex_src_1_o, ex_src_2_o, ex_src_3_o, ex_ctrl_o
   );

   modport master (
      output dec_valid_i, dec_addr_1_i, dec_addr_2_i, dec_addr_3_i,
      output dec_ctrl_i, dec_pc_i, stall_i, flush_i,
      input  ram_addr_1_o, ram_addr_2_o, ram_addr_3_o,
      output ram_data_1_i, ram_data_2_i, ram_data_3_i,
      output wb_en_i, wb_addr_i, wb_data_i,
      input  ex_valid_o, ex_op_1_o, ex_op_2_o, ex_op_3_o,
      input  ex_src_1_o, ex_src_2_o, ex_src_3_o, ex_ctrl_o
   );

endinterface

// File: rtl/reg_read_stage_operand_sel.sv
// Combinational priority mux resolving one source operand from the PC,
// the recorded same-edge writeback, or the register RAM read data.
module operand_sel import reg_read_stage_pkg::*; (
   input  logic  i_valid,
   input  addr_t i_addr,
   input  word_t i_pc_val,
   input  logic  i_byp_en,
   input  addr_t i_byp_addr,
   input  word_t i_byp_data,
   input  word_t i_ram_data,
   output word_t o_op
);

   opsel_e w_sel;

   assign w_sel = f_op_sel(i_valid, i_addr, i_byp_en, i_byp_addr);

   // Pick the operand source chosen by the priority decision.
   always_comb begin
      o_op = '0;
      case (w_sel)
         SEL_ZERO: o_op = '0;
         SEL_PC:   o_op = i_pc_val;
         SEL_BYP:  o_op = i_byp_data;
         SEL_RAM:  o_op = i_ram_data;
         default:  o_op = '0;
      endcase
   end

endmodule

// File: rtl/reg_read_stage.sv
// Decode/register-read stage. Drives the synchronous-read register RAM
// addresses, lines the RAM's one-cycle-late data up with the captured
// control bundle, bypasses a writeback that landed on the same edge as
// the RAM read, substitutes PC+offset for r15, and supports stall
// (hold with re-read) and flush.
module reg_read_stage import reg_read_stage_pkg::*; #(
   parameter int CTRL_W    = 32,
   parameter int PC_OFFSET = 4
) (
   input logic             clk_i,
   input logic             rst_n_i,
   reg_read_stage_if.slave bus
);

   logic              r_valid;
   addr_t             r_addr_1;
   addr_t             r_addr_2;
   addr_t             r_addr_3;
   logic [CTRL_W-1:0] r_ctrl;
   word_t             r_pc;

   logic              r_byp_en;
   addr_t             r_byp_addr;
   word_t             r_byp_data;

   word_t             w_pc_val;

   // While stalled the RAM re-reads the held sources so writes committed
   // during the stall become visible; during reset the addresses are 0.
   assign bus.ram_addr_1_o = !rst_n_i ? '0 : (bus.stall_i ? r_addr_1 : bus.dec_addr_1_i);
   assign bus.ram_addr_2_o = !rst_n_i ? '0 : (bus.stall_i ? r_addr_2 : bus.dec_addr_2_i);
   assign bus.ram_addr_3_o = !rst_n_i ? '0 : (bus.stall_i ? r_addr_3 : bus.dec_addr_3_i);

   // Instruction capture: flush beats stall, stall holds, otherwise load.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_valid  <= 1'b0;
         r_addr_1 <= '0;
         r_addr_2 <= '0;
         r_addr_3 <= '0;
         r_ctrl   <= '0;
         r_pc     <= '0;
      end else if (bus.flush_i) begin
         r_valid  <= 1'b0;
      end else if (!bus.stall_i) begin
         r_valid  <= bus.dec_valid_i;
         r_addr_1 <= bus.dec_addr_1_i;
         r_addr_2 <= bus.dec_addr_2_i;
         r_addr_3 <= bus.dec_addr_3_i;
         r_ctrl   <= bus.dec_ctrl_i;
         r_pc     <= bus.dec_pc_i;
      end
   end

   // Record every writeback: the RAM returned the pre-write value for any
   // read sampled on the same edge, so this record overrides it.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_byp_en <= 1'b0;
      end else begin
         r_byp_en <= bus.wb_en_i;
      end
   end

   // Writeback address/data only matter when r_byp_en is set.
   always_ff @(posedge clk_i) begin
      r_byp_addr <= bus.wb_addr_i;
      r_byp_data <= bus.wb_data_i;
   end

   assign w_pc_val = r_pc + word_t'(PC_OFFSET);

   operand_sel u_sel_1 (
      .i_valid    (r_valid),
      .i_addr     (r_addr_1),
      .i_pc_val   (w_pc_val),
      .i_byp_en   (r_byp_en),
      .i_byp_addr (r_byp_addr),
      .i_byp_data (r_byp_data),
      .i_ram_data (bus.ram_data_1_i),
      .o_op       (bus.ex_op_1_o)
   );

   operand_sel u_sel_2 (
      .i_valid    (r_valid),
      .i_addr     (r_addr_2),
      .i_pc_val   (w_pc_val),
      .i_byp_en   (r_byp_en),
      .i_byp_addr (r_byp_addr),
      .i_byp_data (r_byp_data),
      .i_ram_data (bus.ram_data_2_i),
      .o_op       (bus.ex_op_2_o)
   );

   operand_sel u_sel_3 (
      .i_valid    (r_valid),
      .i_addr     (r_addr_3),
      .i_pc_val   (w_pc_val),
      .i_byp_en   (r_byp_en),
      .i_byp_addr (r_byp_addr),
      .i_byp_data (r_byp_data),
      .i_ram_data (bus.ram_data_3_i),
      .o_op       (bus.ex_op_3_o)
   );

   assign bus.ex_valid_o = r_valid;
   assign bus.ex_src_1_o = r_addr_1;
   assign bus.ex_src_2_o = r_addr_2;
   assign bus.ex_src_3_o = r_addr_3;
   assign bus.ex_ctrl_o  = r_ctrl;

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: a behavioural register RAM around the stage,
// an architectural register-file model, and a scoreboard of the expected
// execute-side view for every cycle.
module tb_reg_read_stage;
   import reg_read_stage_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reg_read_stage_if #(.CTRL_W(32)) bus ();

   reg_read_stage #(.CTRL_W(32), .PC_OFFSET(4)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   // Synchronous-read register RAM: a read on an edge returns the old value.
   logic [31:0] mem [16] = '{default: 32'h0};
   always @(posedge clk) begin
      if (bus.wb_en_i) mem[bus.wb_addr_i] <= bus.wb_data_i;
      bus.ram_data_1_i <= mem[bus.ram_addr_1_o];
      bus.ram_data_2_i <= mem[bus.ram_addr_2_o];
      bus.ram_data_3_i <= mem[bus.ram_addr_3_o];
   end

   // Architectural model: register contents and the instruction in the stage.
   logic [31:0] m_regs [16] = '{default: 32'h0};
   logic        m_valid = 1'b0;
   logic [3:0]  m_src [3] = '{default: 4'h0};
   logic [31:0] m_ctrl = 32'h0;
   logic [31:0] m_pc = 32'h0;

   typedef struct packed {
      logic            valid;
      logic [2:0][31:0] op;
      logic [2:0][3:0]  src;
      logic [31:0]      ctrl;
   } exp_t;

   exp_t sb_q [$];
   logic mon_en = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Operand execute should see: PC+4 for r15, otherwise the register's
   // value after every write committed up to the last edge.
   function automatic logic [31:0] m_op(input int n);
      if (!m_valid) return 32'h0;
      if (m_src[n] == 4'd15) return m_pc + 32'd4;
      return m_regs[m_src[n]];
   endfunction

   function automatic exp_t model_exp();
      exp_t e;
      e.valid = m_valid;
      e.ctrl  = m_ctrl;
      for (int n = 0; n < 3; n++) begin
         e.op[n]  = m_op(n);
         e.src[n] = m_src[n];
      end
      return e;
   endfunction

   // Apply the effect of the edge that just passed, using the inputs that
   // were presented before it.
   task automatic model_edge();
      if (bus.wb_en_i) m_regs[bus.wb_addr_i] = bus.wb_data_i;
      if (!rst_n) begin
         m_valid = 1'b0;
         m_src   = '{default: 4'h0};
         m_ctrl  = 32'h0;
         m_pc    = 32'h0;
      end else if (bus.flush_i) begin
         m_valid = 1'b0;
      end else if (!bus.stall_i) begin
         m_valid  = bus.dec_valid_i;
         m_src[0] = bus.dec_addr_1_i;
         m_src[1] = bus.dec_addr_2_i;
         m_src[2] = bus.dec_addr_3_i;
         m_ctrl   = bus.dec_ctrl_i;
         m_pc     = bus.dec_pc_i;
      end
   endtask

   task automatic step(input logic v, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [3:0] a3, input logic [31:0] ctrl, input logic [31:0] pc,
                       input logic st, input logic fl, input logic we,
                       input logic [3:0] wa, input logic [31:0] wd);
      @(posedge clk);
      #1;
      model_edge();
      bus.dec_valid_i  = v;
      bus.dec_addr_1_i = a1;
      bus.dec_addr_2_i = a2;
      bus.dec_addr_3_i = a3;
      bus.dec_ctrl_i   = ctrl;
      bus.dec_pc_i     = pc;
      bus.stall_i      = st;
      bus.flush_i      = fl;
      bus.wb_en_i      = we;
      bus.wb_addr_i    = wa;
      bus.wb_data_i    = wd;
      if (mon_en) sb_q.push_back(model_exp());
   endtask

   task automatic step_idle();
      step(1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
   endtask

   task automatic step_rand();
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), $urandom, $urandom,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
   endtask

   // Monitor: every cycle compare the execute-side view with the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL sb_empty: got empty queue, expected an entry (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("ex_valid", 32'(bus.ex_valid_o), 32'(e.valid));
            chk("ex_op_1", bus.ex_op_1_o, e.op[0]);
            chk("ex_op_2", bus.ex_op_2_o, e.op[1]);
            chk("ex_op_3", bus.ex_op_3_o, e.op[2]);
            if (e.valid) begin
               chk("ex_src_1", 32'(bus.ex_src_1_o), 32'(e.src[0]));
               chk("ex_src_2", 32'(bus.ex_src_2_o), 32'(e.src[1]));
               chk("ex_src_3", 32'(bus.ex_src_3_o), 32'(e.src[2]));
               chk("ex_ctrl", bus.ex_ctrl_o, e.ctrl);
            end
         end
      end
   end

   initial begin
      bus.dec_valid_i = 1'b0; bus.dec_addr_1_i = '0; bus.dec_addr_2_i = '0;
      bus.dec_addr_3_i = '0;  bus.dec_ctrl_i = '0;   bus.dec_pc_i = '0;
      bus.stall_i = 1'b0;     bus.flush_i = 1'b0;    bus.wb_en_i = 1'b0;
      bus.wb_addr_i = '0;     bus.wb_data_i = '0;

      // Reset held for two cycles with random inputs.
      rst_n = 1'b0;
      repeat (2) begin
         step_rand();
         @(negedge clk);
         chk("rst_valid", 32'(bus.ex_valid_o), 32'h0);
         chk("rst_op_1", bus.ex_op_1_o, 32'h0);
         chk("rst_op_2", bus.ex_op_2_o, 32'h0);
         chk("rst_op_3", bus.ex_op_3_o, 32'h0);
         chk("rst_src", 32'({bus.ex_src_1_o, bus.ex_src_2_o, bus.ex_src_3_o}), 32'h0);
         chk("rst_ctrl", bus.ex_ctrl_o, 32'h0);
         chk("rst_ram_addr", 32'({bus.ram_addr_1_o, bus.ram_addr_2_o, bus.ram_addr_3_o}), 32'h0);
      end
      step_idle();
      rst_n  = 1'b1;
      mon_en = 1'b1;
      sb_q.push_back(model_exp());

      // Preload r3, r4, r5, r6 through the writeback port.
      step(1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd3, 32'h11);
      step(1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd4, 32'h22);
      step(1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd5, 32'h0);
      step(1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd6, 32'h1);

      // Plain read of r3, r4, r0.
      step(1'b1, 4'd3, 4'd4, 4'd0, 32'hC0DE, 32'h40, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      step_idle();
      @(negedge clk);
      chk("plain_valid", 32'(bus.ex_valid_o), 32'h1);
      chk("plain_op_1", bus.ex_op_1_o, 32'h11);
      chk("plain_op_2", bus.ex_op_2_o, 32'h22);
      chk("plain_src_1", 32'(bus.ex_src_1_o), 32'h3);

      // Same-edge write and read of r5.
      step(1'b1, 4'd5, 4'd0, 4'd0, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1, 4'd5, 32'hDEAD);
      step_idle();
      @(negedge clk);
      chk("collide_op_1", bus.ex_op_1_o, 32'hDEAD);

      // r15 reads PC+4 even with a simultaneous write to r15.
      step(1'b1, 4'd0, 4'd15, 4'd0, 32'h2, 32'h100, 1'b0, 1'b0, 1'b1, 4'd15, 32'h5555);
      step_idle();
      @(negedge clk);
      chk("pc_op_2", bus.ex_op_2_o, 32'h104);

      // Stall for three cycles with a write to r6 in the first stalled cycle.
      step(1'b1, 4'd6, 4'd3, 4'd0, 32'hABCD, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      step(1'b1, 4'd9, 4'd9, 4'd9, 32'h9, 32'h9, 1'b1, 1'b0, 1'b1, 4'd6, 32'h7);
      @(negedge clk);
      chk("stall1_op_1", bus.ex_op_1_o, 32'h1);
      step(1'b1, 4'd9, 4'd9, 4'd9, 32'h9, 32'h9, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
      @(negedge clk);
      chk("stall2_op_1", bus.ex_op_1_o, 32'h7);
      chk("stall2_valid", 32'(bus.ex_valid_o), 32'h1);
      chk("stall2_ctrl", bus.ex_ctrl_o, 32'hABCD);
      chk("stall2_src_1", 32'(bus.ex_src_1_o), 32'h6);
      step(1'b1, 4'd9, 4'd9, 4'd9, 32'h9, 32'h9, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
      step(1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      @(negedge clk);
      chk("release_op_1", bus.ex_op_1_o, 32'h7);

      // Flush wins over stall; the next decode passes normally.
      step(1'b1, 4'd3, 4'd0, 4'd0, 32'h3, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      step(1'b1, 4'd3, 4'd0, 4'd0, 32'h3, 32'h0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0);
      step(1'b1, 4'd4, 4'd0, 4'd0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      @(negedge clk);
      chk("flush_valid", 32'(bus.ex_valid_o), 32'h0);
      chk("flush_op_1", bus.ex_op_1_o, 32'h0);
      step_idle();
      @(negedge clk);
      chk("after_flush_valid", 32'(bus.ex_valid_o), 32'h1);
      chk("after_flush_op_1", bus.ex_op_1_o, 32'h22);

      // Randomized traffic.
      repeat (1500) step_rand();
      repeat (3) step_idle();
      @(negedge clk);
      #1;
      mon_en = 1'b0;

      // Reset asserted while an instruction is held by a stall.
      step(1'b1, 4'd3, 4'd4, 4'd0, 32'h5, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      step(1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
      @(negedge clk);
      chk("held_valid", 32'(bus.ex_valid_o), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("midstall_rst_valid", 32'(bus.ex_valid_o), 32'h0);
      chk("midstall_rst_op_1", bus.ex_op_1_o, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
